// File: rtl/car_sequencer_if.sv
// Bundle of decoder, control-ROM and sequencer status signals around the CAR sequencer.
interface car_sequencer_if #(
  parameter int unsigned CarBits = 6
);
  logic [CarBits-1:0] car_dec;
  logic               ir_valid;
  logic               mem_ready;
  logic [1:0]         seq_op;
  logic [CarBits-1:0] seq_target;
  logic               int_req;
  logic [CarBits-1:0] car;
  logic               fetch_req;
  logic               int_ack;
  logic               fault;
  logic [3:0]         ustep;

  // Environment side: decoder, fetch unit, control ROM, interrupt controller.
  modport master (
    output car_dec, ir_valid, mem_ready, seq_op, seq_target, int_req,
    input  car, fetch_req, int_ack, fault, ustep
  );

  // Sequencer side.
  modport slave (
    input  car_dec, ir_valid, mem_ready, seq_op, seq_target, int_req,
    output car, fetch_req, int_ack, fault, ustep
  );
endinterface

// File: rtl/car_sequencer.sv
// Control Address Register sequencer: loads decoder start addresses, steps/branches under
// control-ROM direction, inserts interrupt entry between instructions.
module car_sequencer #(
  parameter int unsigned           CarBits   = 6,
  parameter logic [CarBits-1:0]    FetchAddr = 6'h00,
  parameter logic [CarBits-1:0]    IntAddr   = 6'h3C
) (
  input logic                MCLK,
  input logic                reset,
  car_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StExec  = 2'b01,
    StInt   = 2'b10
  } state_e;

  localparam logic [1:0] OpNext = 2'b00;
  localparam logic [1:0] OpJump = 2'b01;
  localparam logic [1:0] OpDone = 2'b10;
  localparam logic [1:0] OpHold = 2'b11;

  localparam logic [CarBits-1:0] CarMax = '1;

  state_e             state_q, state_d;
  logic [CarBits-1:0] car_q, car_d;
  logic [3:0]         ustep_q, ustep_d;
  logic               int_ack_q, int_ack_d;
  logic               fault_q, fault_d;

  // Next-state, next-CAR and pulse generation; mem_ready low freezes everything.
  always_comb begin
    state_d   = state_q;
    car_d     = car_q;
    ustep_d   = ustep_q;
    int_ack_d = 1'b0;
    fault_d   = 1'b0;
    if (bus.mem_ready) begin
      unique case (state_q)
        StFetch: begin
          // Interrupt wins over a freshly latched IW; the IW is simply refetched later.
          if (bus.int_req) begin
            state_d   = StInt;
            car_d     = IntAddr;
            int_ack_d = 1'b1;
            ustep_d   = 4'd0;
          end else if (bus.ir_valid) begin
            state_d = StExec;
            car_d   = bus.car_dec;
            ustep_d = 4'd0;
          end
        end
        StExec, StInt: begin
          ustep_d = (ustep_q == 4'hF) ? ustep_q : ustep_q + 4'd1;
          unique case (bus.seq_op)
            OpNext: begin
              // Running off the top of the ROM aborts the instruction instead of wrapping.
              if (car_q == CarMax) begin
                fault_d = 1'b1;
                state_d = StFetch;
                car_d   = FetchAddr;
              end else begin
                car_d = car_q + CarBits'(1);
              end
            end
            OpJump: begin
              car_d = bus.seq_target;
            end
            OpDone: begin
              // Interrupts are only taken between instructions, never nested from StInt.
              if ((state_q == StExec) && bus.int_req) begin
                state_d   = StInt;
                car_d     = IntAddr;
                int_ack_d = 1'b1;
                ustep_d   = 4'd0;
              end else begin
                state_d = StFetch;
                car_d   = FetchAddr;
              end
            end
            OpHold: begin
              car_d = car_q;
            end
            default: begin
              car_d = car_q;
            end
          endcase
        end
        default: begin
          state_d = StFetch;
          car_d   = FetchAddr;
        end
      endcase
    end
  end

  // State, CAR, step counter and pulse registers with synchronous reset.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q   <= StFetch;
      car_q     <= FetchAddr;
      ustep_q   <= 4'd0;
      int_ack_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      car_q     <= car_d;
      ustep_q   <= ustep_d;
      int_ack_q <= int_ack_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.car       = car_q;
  assign bus.fetch_req = (state_q == StFetch);
  assign bus.int_ack   = int_ack_q;
  assign bus.fault     = fault_q;
  assign bus.ustep     = ustep_q;

endmodule
